// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem req/ack handshake, instruction register
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc4,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_target
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        unused_target_bits;

    assign pc_plus4           = pc + 32'd4;
    assign imem_req           = (state == S_FETCH);
    assign imem_addr          = pc;
    assign unused_target_bits = ^branch_target[1:0];

    // Jump wins over branch; only consulted in the consume cycle.
    always_comb begin
        next_pc = instr_pc4;
        if (jump) begin
            next_pc = {instr_pc4[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            next_pc = {branch_target[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_pc4   <= 32'h0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc4   <= pc_plus4;
                        instr_valid <= 1'b1;
                        state       <= S_VALID;
                    end
                end
                S_VALID: begin
                    // instr/instr_pc4 stay put on consume; only valid drops.
                    if (!stall) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        state       <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [31:0] instr_pc4;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [25:0] jump_target = 26'h0;

    logic        reset2 = 1'b1;
    logic        req2;
    logic [31:0] addr2;
    logic        ack2 = 1'b0;
    logic [31:0] rdata2 = 32'h0;
    logic [31:0] instr2;
    logic [31:0] pc4_2;
    logic        valid2;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc4(instr_pc4), .instr_valid(instr_valid),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
        .clk(clk), .reset(reset2),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2),
        .instr(instr2), .instr_pc4(pc4_2), .instr_valid(valid2),
        .stall(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
        .jump(1'b0), .jump_target(26'h0)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    logic [31:0] exp_instr = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic score(input string tag, input logic [31:0] got_instr, input logic [31:0] got_pc4);
        logic [63:0] e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got capture expected empty scoreboard entry", tag);
        end else begin
            e = sb.pop_front();
            exp_instr = e[63:32];
            check({tag, "_instr"}, got_instr, e[63:32]);
            check({tag, "_pc4"}, got_pc4, e[31:0]);
        end
    endtask

    // Entered in a FETCH cycle; leaves in the VALID cycle after capture.
    task automatic fetch(input string tag, input logic [31:0] addr, input int delay, input logic [31:0] word);
        check({tag, "_req"}, 32'(imem_req), 32'd1);
        check({tag, "_addr"}, imem_addr, addr);
        for (int i = 0; i < delay; i++) begin
            step();
            check({tag, "_wait_req"}, 32'(imem_req), 32'd1);
            check({tag, "_wait_addr"}, imem_addr, addr);
            check({tag, "_wait_valid"}, 32'(instr_valid), 32'd0);
            check({tag, "_wait_instr"}, instr, exp_instr);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        sb.push_back({word, addr + 32'd4});
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_req_low"}, 32'(imem_req), 32'd0);
        score(tag, instr, instr_pc4);
    endtask

    task automatic consume(input string tag, input logic br, input logic [31:0] bt,
                           input logic j, input logic [25:0] jt, input logic [31:0] exp_addr);
        stall         = 1'b0;
        branch_taken  = br;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        step();
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 26'h0;
        check({tag, "_req"}, 32'(imem_req), 32'd1);
        check({tag, "_addr"}, imem_addr, exp_addr);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    endtask

    initial begin
        step();
        step();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc4", instr_pc4, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);

        reset = 1'b0;
        check("idle_req", 32'(imem_req), 32'd0);
        step();
        fetch("first", 32'h0, 0, 32'h8C08_0004);
        consume("seq0", 1'b0, 32'h0, 1'b0, 26'h0, 32'h4);
        fetch("second", 32'h4, 0, 32'h2109_0001);
        consume("seq1", 1'b0, 32'h0, 1'b0, 26'h0, 32'h8);

        stall = 1'b1;
        fetch("delayed", 32'h8, 3, 32'hAC0A_0008);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                imem_ack      = 1'b1;
                imem_rdata    = 32'hDEAD_BEEF;
                branch_taken  = 1'b1;
                branch_target = 32'h0000_0100;
                jump          = 1'b1;
            end
            step();
            imem_ack      = 1'b0;
            imem_rdata    = 32'h0;
            branch_taken  = 1'b0;
            branch_target = 32'h0;
            jump          = 1'b0;
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_req", 32'(imem_req), 32'd0);
            check("stall_instr", instr, 32'hAC0A_0008);
            check("stall_addr", imem_addr, 32'h8);
        end
        consume("seq2", 1'b0, 32'h0, 1'b0, 26'h0, 32'hC);

        fetch("pre_branch", 32'hC, 1, 32'h1000_0005);
        consume("branch", 1'b1, 32'h0000_0043, 1'b0, 26'h0, 32'h40);
        fetch("pre_jump", 32'h40, 0, 32'h0800_0010);
        consume("jump_prio", 1'b1, 32'h0000_1003, 1'b1, 26'h10, 32'h40);

        step();
        step();
        check("mid_req", 32'(imem_req), 32'd1);
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        #1;
        check("async_req", 32'(imem_req), 32'd0);
        check("async_addr", imem_addr, 32'h0);
        check("async_instr", instr, 32'h0);
        check("async_pc4", instr_pc4, 32'h0);
        check("async_valid", 32'(instr_valid), 32'd0);
        step();
        check("rst_ack_instr", instr, 32'h0);
        check("rst_ack_valid", 32'(instr_valid), 32'd0);
        reset = 1'b0;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check("late_ack_instr", instr, 32'h0);
        check("late_ack_valid", 32'(instr_valid), 32'd0);
        exp_instr = 32'h0;
        fetch("restart", 32'h0, 0, 32'h3C01_0002);
        consume("restart_seq", 1'b0, 32'h0, 1'b0, 26'h0, 32'h4);

        check("hi_rst_addr", addr2, 32'hFFFF_FFFC);
        check("hi_rst_req", 32'(req2), 32'd0);
        reset2 = 1'b0;
        step();
        check("hi_req", 32'(req2), 32'd1);
        check("hi_addr", addr2, 32'hFFFF_FFFC);
        ack2   = 1'b1;
        rdata2 = 32'h0000_0020;
        sb.push_back({32'h0000_0020, 32'hFFFF_FFFC + 32'd4});
        step();
        ack2   = 1'b0;
        rdata2 = 32'h0;
        check("hi_valid", 32'(valid2), 32'd1);
        score("hi_wrap", instr2, pc4_2);
        step();
        check("hi_next_req", 32'(req2), 32'd1);
        check("hi_next_addr", addr2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
